// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and default size.
package arb_pkg;
  localparam logic ARB_IDLE  = 1'b0;
  localparam logic ARB_GRANT = 1'b1;
  localparam int   ARB_N_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE  = ARB_IDLE,
    ST_GRANT = ARB_GRANT
  } arb_state_t;
endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters plus consumer (master) and the arbiter (slave).
// The lock signal exists only when RR_ARB_LOCK_EN is defined.
interface rr_arbiter_if import arb_pkg::*; #(
  parameter int N = ARB_N_DEFAULT,
  parameter int W = $clog2(N)
);
  logic [N-1:0] req;
  logic         ack;
`ifdef RR_ARB_LOCK_EN
  logic         lock;
`endif
  logic [N-1:0] grant;
  logic [W-1:0] grant_idx;
  logic         valid;

  modport master (
    output req, ack,
`ifdef RR_ARB_LOCK_EN
    output lock,
`endif
    input  grant, grant_idx, valid
  );

  modport slave (
    input  req, ack,
`ifdef RR_ARB_LOCK_EN
    input  lock,
`endif
    output grant, grant_idx, valid
  );
endinterface

// File: rtl/rr_arbiter_prio_arb.sv
// Combinational fixed-priority arbiter, bit 0 highest, built as a ripple carry chain.
module prio_arb #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  // carry[i] is high while no lower-indexed request has been seen
  logic [N-1:0] carry;

  assign carry[0] = 1'b1;

  generate
    for (genvar gi = 1; gi < N; gi++) begin : g_chain
      assign carry[gi] = ~req[gi-1] & carry[gi-1];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_grant
      assign grant[gi] = req[gi] & carry[gi];
    end
  endgenerate
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, binary index and accept handshake.
// Define RR_ARB_LOCK_EN to add the lock input that holds a grant across accepts.
module rr_arbiter import arb_pkg::*; #(
  parameter int N = ARB_N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input logic         clk,
  input logic         reset,
  rr_arbiter_if.slave bus
);
  function automatic logic [W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | W'(i);
    end
    return idx;
  endfunction

  arb_state_t   state_reg;
  logic [W-1:0] ptr_reg;
  logic [N-1:0] grant_reg;
  logic [W-1:0] idx_reg;

  logic [W-1:0] next_ptr;
  logic [W-1:0] arb_ptr;
  logic [N-1:0] mask;
  logic [N-1:0] masked_req;
  logic [N-1:0] win_masked;
  logic [N-1:0] win_plain;
  logic [N-1:0] winner;
  logic [W-1:0] winner_idx;
  logic         do_release;

  assign next_ptr = (idx_reg == W'(N - 1)) ? '0 : idx_reg + W'(1);
  // On a release the new pointer must already steer this cycle's arbitration
  assign arb_ptr  = (state_reg == ST_GRANT) ? next_ptr : ptr_reg;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign mask[gi] = (arb_ptr <= W'(gi));
    end
  endgenerate

  assign masked_req = bus.req & mask;

  prio_arb #(.N(N)) u_prio_masked (.req(masked_req), .grant(win_masked));
  prio_arb #(.N(N)) u_prio_plain  (.req(bus.req),    .grant(win_plain));

  assign winner     = (|masked_req) ? win_masked : win_plain;
  assign winner_idx = onehot_to_idx(winner);

`ifdef RR_ARB_LOCK_EN
  assign do_release = bus.ack & ~bus.lock;
`else
  assign do_release = bus.ack;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|bus.req) begin
            state_reg <= ST_GRANT;
            grant_reg <= winner;
            idx_reg   <= winner_idx;
          end
        end
        ST_GRANT: begin
          if (do_release) begin
            ptr_reg <= next_ptr;
            if (|bus.req) begin
              grant_reg <= winner;
              idx_reg   <= winner_idx;
            end else begin
              state_reg <= ST_IDLE;
              grant_reg <= '0;
              idx_reg   <= '0;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant     = grant_reg;
  assign bus.grant_idx = idx_reg;
  assign bus.valid     = (state_reg == ST_GRANT);
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter (N=4): directed scenarios then random traffic,
// checked against a rotating-search reference model.
module tb_rr_arbiter;
  localparam int N = 4;
  localparam int W = 2;
`ifdef RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct packed {
    logic         valid;
    logic [N-1:0] grant;
    logic [W-1:0] idx;
  } exp_t;

  logic clk;
  logic reset;
  rr_arbiter_if #(.N(N), .W(W)) bus ();

  rr_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  // Reference model: plain integers, rotating search from the pointer
  int m_valid = 0;
  int m_idx   = 0;
  int m_ptr   = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic a, input logic l, input logic rs);
    int w;
    if (rs) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else if (m_valid == 0) begin
      w = pick(r, m_ptr);
      if (w >= 0) begin m_valid = 1; m_idx = w; end
    end else if (a && !(LOCK_EN && l)) begin
      m_ptr = (m_idx + 1) % N;
      w = pick(r, m_ptr);
      if (w >= 0) m_idx = w;
      else begin m_valid = 0; m_idx = 0; end
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic a, input logic l, input logic rs);
    exp_t e;
    @(negedge clk);
    bus.req = r;
    bus.ack = a;
`ifdef RR_ARB_LOCK_EN
    bus.lock = l;
`endif
    reset = rs;
    model_step(r, a, l, rs);
    e.valid = (m_valid != 0);
    e.grant = (m_valid != 0) ? N'(1 << m_idx) : '0;
    e.idx   = W'(m_idx);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic expect_now(input string name, input logic v, input logic [N-1:0] g);
    tests++;
    if (bus.valid !== v || bus.grant !== g) begin
      fails++;
      $display("FAIL %s: got valid=%0b grant=%b, expected valid=%0b grant=%b",
               name, bus.valid, bus.grant, v, g);
    end
  endtask

  // Monitor: one scoreboard entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        tests++;
        if (bus.valid !== e.valid || bus.grant !== e.grant || bus.grant_idx !== e.idx) begin
          fails++;
          $display("FAIL sb: got v=%0b g=%b i=%0d, expected v=%0b g=%b i=%0d",
                   bus.valid, bus.grant, bus.grant_idx, e.valid, e.grant, e.idx);
        end else begin
          $display("[TB] ok v=%0b g=%b i=%0d", bus.valid, bus.grant, bus.grant_idx);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] rot_exp [4];
    logic [N-1:0] hold_req [5];
    rot_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    hold_req = '{4'b0100, 4'b0000, 4'b1011, 4'b0011, 4'b1011};
    bus.req = '0;
    bus.ack = 1'b0;
`ifdef RR_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    reset = 1'b1;

    // Reset held with all requests present
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b0, 1'b0, 1'b1);
      expect_now("reset_hold", 1'b0, 4'b0000);
    end
    cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    expect_now("first_grant", 1'b1, 4'b0001);

    // Rotation, no bubbles
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1111, 1'b1, 1'b0, 1'b0);
      expect_now("rotation", 1'b1, rot_exp[i]);
    end

    // Skip and wrap
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    expect_now("serve_2", 1'b1, 4'b0100);
    cycle(4'b0011, 1'b1, 1'b0, 1'b0);
    expect_now("wrap_0011", 1'b1, 4'b0001);
    cycle(4'b1001, 1'b1, 1'b0, 1'b0);
    expect_now("skip_1001", 1'b1, 4'b1000);

    // Hold while ack is low
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    expect_now("hold_setup", 1'b1, 4'b0100);
    for (int i = 0; i < 5; i++) begin
      cycle(hold_req[i], 1'b0, 1'b0, 1'b0);
      expect_now("hold", 1'b1, 4'b0100);
    end
    cycle(4'b1011, 1'b1, 1'b0, 1'b0);
    expect_now("hold_release", 1'b1, 4'b1000);

    // Release to idle, stray ack, reset mid-grant
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    expect_now("to_idle", 1'b0, 4'b0000);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);
    expect_now("stray_ack", 1'b0, 4'b0000);
    cycle(4'b0010, 1'b0, 1'b0, 1'b0);
    expect_now("grant_1", 1'b1, 4'b0010);
    cycle(4'b1111, 1'b0, 1'b0, 1'b1);
    expect_now("reset_mid", 1'b0, 4'b0000);
    cycle(4'b1111, 1'b0, 1'b0, 1'b0);
    expect_now("ptr_cleared", 1'b1, 4'b0001);

`ifdef RR_ARB_LOCK_EN
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    expect_now("lock_setup", 1'b1, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b1111, 1'b1, 1'b1, 1'b0);
      expect_now("lock_hold", 1'b1, 4'b0010);
    end
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    expect_now("lock_release", 1'b1, 4'b0100);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      cycle(N'($urandom_range(0, (1 << N) - 1)),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 49) == 0));
    end

    cycle(4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
